// File: rtl/mem_master.sv
// Burst initiator for the single-port synchronous mem block: turns 1..8 word
// read/write requests into registered chipSel/addr/write/dat bus cycles.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | bus parked (chipSel=0), waiting for a request
// S_WRITE | accepting write beats, one bus write per accepted beat
// S_READ  | issuing one read address per cycle
// S_DRAIN | bus holds last beat while memory commits/returns it
// S_DONE  | done pulse, bus released for turnaround
module mem_master #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic              chipSel,
   output logic [ADDR_W-1:0] addr,
   output logic              write,
   inout  wire  [DATA_W-1:0] dat
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] acnt_q;
   logic [LEN_W-1:0]  left_q;
   logic              cs_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdat_q;
   logic              ret_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;

   logic [ADDR_W-1:0] acnt_inc_d;
   logic [ADDR_W-1:0] req_inc_d;
   logic [LEN_W-1:0]  left_dec_d;

   always_comb begin
      acnt_inc_d = acnt_q + ADDR_W'(1);
      req_inc_d  = req_addr + ADDR_W'(1);
      left_dec_d = left_q - LEN_W'(1);
   end

   assign req_ready   = (state_q == S_IDLE);
   assign wdata_ready = (state_q == S_WRITE);
   assign done        = (state_q == S_DONE);
   assign chipSel     = cs_q;
   assign write       = we_q;
   assign addr        = addr_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign dat         = (cs_q & we_q) ? wdat_q : {DATA_W{1'bz}};

   // left_q counts beats still to go after the current one; zero is terminal.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acnt_q   <= '0;
         left_q   <= '0;
         cs_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdat_q   <= '0;
         ret_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         // Address shown in READ is driven by memory one cycle later.
         ret_q    <= (state_q == S_READ);
         rvalid_q <= ret_q;
         if (ret_q) begin
            rdata_q <= dat;
         end

         case (state_q)
            S_IDLE: begin
               cs_q <= 1'b0;
               we_q <= 1'b0;
               if (req_valid) begin
                  left_q <= req_len;
                  if (req_write) begin
                     acnt_q  <= req_addr;
                     state_q <= S_WRITE;
                  end else begin
                     cs_q    <= 1'b1;
                     addr_q  <= req_addr;
                     acnt_q  <= req_inc_d;
                     state_q <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               if (wdata_valid) begin
                  cs_q   <= 1'b1;
                  we_q   <= 1'b1;
                  addr_q <= acnt_q;
                  wdat_q <= wdata;
                  acnt_q <= acnt_inc_d;
                  if (left_q == '0) begin
                     state_q <= S_DRAIN;
                  end else begin
                     left_q <= left_dec_d;
                  end
               end else begin
                  cs_q <= 1'b0;
                  we_q <= 1'b0;
               end
            end
            S_READ: begin
               if (left_q == '0) begin
                  state_q <= S_DRAIN;
               end else begin
                  addr_q <= acnt_q;
                  acnt_q <= acnt_inc_d;
                  left_q <= left_dec_d;
               end
            end
            S_DRAIN: begin
               cs_q    <= 1'b0;
               we_q    <= 1'b0;
               state_q <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator for the single-port synchronous `mem` block: drives `chipSel`, `addr`, `write` and the shared tri-state `dat` bus on behalf of a requester.
- Accepts a read or write burst of 1..8 words through a valid/ready request port.
- Streams write data in through a valid/ready port and read data out through a valid strobe.
- Sits between the pipeline's load/store stage and the data memory; it is the other end of the `mem` interface.

## Interface
Parameters:
- `ADDR_W`, 8, memory address width (address arithmetic wraps modulo 2^ADDR_W)
- `DATA_W`, 32, word width of `dat`, `wdata`, `rdata`
- `LEN_W`, 3, width of `req_len`; burst length = `req_len`+1 (1..8)

Ports:
- `clk`  in  1  single clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  high iff state IDLE
- `req_write`  in  1  1 = write burst, 0 = read burst
- `req_addr`  in  ADDR_W  first word address
- `req_len`  in  LEN_W  beats minus one
- `wdata`  in  DATA_W  write beat data
- `wdata_valid`  in  1  write beat present
- `wdata_ready`  out  1  high in WRITE while beats remain
- `rdata`  out  DATA_W  captured read word
- `rdata_valid`  out  1  one-cycle strobe per read beat
- `done`  out  1  one-cycle pulse, burst complete
- `chipSel`  out  1  memory select (registered)
- `addr`  out  ADDR_W  memory address (registered)
- `write`  out  1  memory write enable (registered)
- `dat`  inout  DATA_W  driven with write-data register iff `chipSel & write`, else high-Z

## Operation
- Memory contract:
  - At posedge with `chipSel=1, write=1`, the memory stores `dat` at `addr`.
  - At posedge with `chipSel=1, write=0`, it registers `mem[addr]`.
  - It drives that register onto `dat` while `chipSel=1, write=0`.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - `chipSel=0`, `write=0`, `dat` Z.
  - `req_valid & req_ready` latches write flag, address and beat count.
  - → WRITE or READ.
- WRITE:
  - Each cycle with `wdata_valid & wdata_ready` accepts a beat.
  - At that edge the bus registers load `chipSel=1`, `write=1`, `addr`=current address, data=`wdata`; the address then increments.
  - Cycle without a beat: bus registers load `chipSel=0`, `write=0`.
  - Edge accepting the last beat → DRAIN.
- READ:
  - Entry edge loads `addr`=A0, `chipSel=1`, `write=0`.
  - Each following edge loads the next address until N addresses are issued.
  - The edge ending the cycle showing the Nth address → DRAIN.
- DRAIN (one cycle):
  - Bus holds its last values (`chipSel=1`).
  - Write: memory commits the last beat at its end.
  - Read: memory drives the last word.
  - → DONE, with bus registers loading `chipSel=0`, `write=0`.
- DONE (one cycle): `done=1`, then → IDLE.
- Read capture:
  - An address shown in cycle c is returned on `dat` in cycle c+1 and captured at the end of c+1.
  - `rdata`/`rdata_valid` appear in cycle c+2; `rdata` holds its value between strobes.
- Address wrap: 255+1 = 0 within a burst; no error.
- `wdata_valid` outside WRITE is ignored (`wdata_ready=0`); `req_valid` outside IDLE is ignored.
- Reset:
  - `rst` overrides everything, including mid-burst. A burst aborted by reset produces no `done` and no further `rdata_valid`.
  - Next cycle: state IDLE, `chipSel=0`, `write=0`, `dat` Z, `addr=0`, `rdata=0`, `rdata_valid=0`, `done=0`, `req_ready=1`, `wdata_ready=0`.

## Timing
- Request accepted at edge E.
- Read, N beats:
  - Addresses shown in cycles E+1..E+N.
  - DRAIN in cycle E+N+1.
  - `rdata_valid` in cycles E+3..E+N+2.
  - DONE in cycle E+N+2, with `done` coincident with the last `rdata_valid`.
  - `req_ready` returns in cycle E+N+3.
- Write, N beats, no stalls:
  - `wdata_ready` in cycles E+1..E+N.
  - Bus shows beats in cycles E+2..E+N+1 (the last one in DRAIN).
  - DONE in cycle E+N+2.
  - Each stall cycle adds one cycle.
- `req_ready`, `wdata_ready`, `done` decode from state; bus outputs and `rdata`/`rdata_valid` are registered.
- Back-to-back requests: at least one IDLE cycle with `chipSel=0` separates bursts (bus turnaround).

## Test plan
- Single write then read: write addr 1 data 15, then read addr 1 → `dat`=15 with `chipSel=write=1` for exactly one cycle; then `rdata=15`, `rdata_valid`, `done` all in the same cycle, 3 cycles after read accept.
- 4-beat write burst at addr 2 with data 14,13,12,11, `wdata_valid` dropped for 2 cycles after beat 2 → `chipSel=0` for 2 cycles; memory 2..5 holds 14..11; `done` 8 cycles after accept.
- 8-beat read burst at addr 2 after preloading memory 2..9 → 8 consecutive `rdata_valid` strobes in cycles E+3..E+10, in order; `done` at E+10.
- Wrap: 3-beat write at addr 254 (data 1,2,3), then read back 254,255,0 → 1,2,3.
- `rst` asserted during beat 3 of an 8-beat read → next cycle `chipSel=0`, `req_ready=1`, no `done`, no further `rdata_valid`; a new 1-beat read at addr 34 then completes normally.
- `req_valid` held during a burst and `wdata_valid` held while in IDLE → neither is accepted; memory is unchanged; exactly one `done` per accepted request.
